// File: rtl/id_regfile_stage_pkg.sv
// Shared types for the decode/register-file stage.
package id_regfile_stage_pkg;

    typedef enum logic {
        WB_IN   = 1'b0,
        WB_AORD = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/id_regfile_stage_regfile_bypass.sv
// Register array with one write port and two combinational read ports bypassed from the write port.
// Latency: writes land on the clock edge, reads are same-cycle. Backpressure: none, always accepts writes.
// Optional hard-wired zero register 0.
module regfile_bypass #(
    parameter int DW      = 8,
    parameter int NREG    = 4,
    parameter int AW      = $clog2(NREG),
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    localparam bit ZR = (ZERO_R0 != 0);

    logic [DW-1:0] regs [NREG];
    logic          wr_en;

    assign wr_en = we && !(ZR && (waddr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Hard zero takes precedence over the bypass so r0 never sees write data.
    assign rdata_a = (ZR && (raddr_a == '0))        ? '0    :
                     (we && (waddr == raddr_a))     ? wdata : regs[raddr_a];
    assign rdata_b = (ZR && (raddr_b == '0))        ? '0    :
                     (we && (waddr == raddr_b))     ? wdata : regs[raddr_b];

endmodule

// File: rtl/id_regfile_stage.sv
// Decode stage: register file read with write-back bypass, registered into the ID/EX stage.
// Latency: operands appear on ex_a/ex_b one cycle after acceptance.
// Backpressure: id_ready drops while ID/EX holds an instruction EX has not taken; flush kills it.
module id_regfile_stage
    import id_regfile_stage_pkg::*;
#(
    parameter int DW      = 8,
    parameter int NREG    = 4,
    parameter int AW      = $clog2(NREG),
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic [AW-1:0] rd_addr,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic          wb_sel,
    input  logic [DW-1:0] wb_in,
    input  logic [DW-1:0] wb_aord,
    input  logic          flush,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [AW-1:0] ex_rd
);

    wb_sel_e       sel;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;

    assign sel     = wb_sel_e'(wb_sel);
    assign wb_data = (sel == WB_AORD) ? wb_aord : wb_in;

    regfile_bypass #(
        .DW      (DW),
        .NREG    (NREG),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (ra_addr),
        .raddr_b (rb_addr),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    assign id_ready = !ex_valid || ex_ready;

    // Flush only clears the valid bit; operand fields keep their last contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (id_valid && id_ready) begin
            ex_valid <= 1'b1;
            ex_a     <= rd_a;
            ex_b     <= rd_b;
            ex_rd    <= rd_addr;
        end else if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_regfile_stage.sv
// Drives a default 8-bit/4-register stage and a 16-bit/8-register zero-r0 stage from one stimulus
// stream and checks both against an array-based model every cycle.
module tb_id_regfile_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  ra_addr = '0, rb_addr = '0, rd_addr = '0, wb_addr = '0;
    logic        wb_we = 1'b0, wb_sel = 1'b0, flush = 1'b0, ex_ready = 1'b1;
    logic [15:0] wb_in = '0, wb_aord = '0;

    logic        id_ready0, ex_valid0, id_ready1, ex_valid1;
    logic [7:0]  ex_a0, ex_b0;
    logic [1:0]  ex_rd0;
    logic [15:0] ex_a1, ex_b1;
    logic [2:0]  ex_rd1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_regfile_stage #(.DW(8), .NREG(4), .ZERO_R0(0)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready0),
        .ra_addr(ra_addr[1:0]), .rb_addr(rb_addr[1:0]), .rd_addr(rd_addr[1:0]),
        .wb_we(wb_we), .wb_addr(wb_addr[1:0]), .wb_sel(wb_sel),
        .wb_in(wb_in[7:0]), .wb_aord(wb_aord[7:0]), .flush(flush),
        .ex_valid(ex_valid0), .ex_ready(ex_ready), .ex_a(ex_a0), .ex_b(ex_b0), .ex_rd(ex_rd0)
    );

    id_regfile_stage #(.DW(16), .NREG(8), .ZERO_R0(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready1),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_sel(wb_sel),
        .wb_in(wb_in), .wb_aord(wb_aord), .flush(flush),
        .ex_valid(ex_valid1), .ex_ready(ex_ready), .ex_a(ex_a1), .ex_b(ex_b1), .ex_rd(ex_rd1)
    );

    // Model: per instance, a plain array; a same-cycle write is applied before the read,
    // which is exactly what the bypass must look like from outside.
    logic [15:0] m_reg [2][8];
    bit          m_v   [2];
    logic [15:0] m_a   [2];
    logic [15:0] m_b   [2];
    logic [2:0]  m_rd  [2];
    logic [2:0]  am    [2] = '{3'd3, 3'd7};
    logic [15:0] dm    [2] = '{16'h00FF, 16'hFFFF};
    bit          zr    [2] = '{1'b0, 1'b1};

    always @(posedge clk or negedge rst) begin
        logic [2:0] ra, rb, wa;
        bit         acc;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                for (int i = 0; i < 8; i++) m_reg[k][i] = '0;
                m_v[k] = 1'b0; m_a[k] = '0; m_b[k] = '0; m_rd[k] = '0;
            end else begin
                ra  = ra_addr & am[k];
                rb  = rb_addr & am[k];
                wa  = wb_addr & am[k];
                acc = id_valid && (!m_v[k] || ex_ready);
                if (wb_we && !(zr[k] && wa == 3'd0))
                    m_reg[k][wa] = (wb_sel ? wb_aord : wb_in) & dm[k];
                if (flush) begin
                    m_v[k] = 1'b0;
                end else if (acc) begin
                    m_v[k]  = 1'b1;
                    m_a[k]  = (zr[k] && ra == 3'd0) ? 16'h0 : m_reg[k][ra];
                    m_b[k]  = (zr[k] && rb == 3'd0) ? 16'h0 : m_reg[k][rb];
                    m_rd[k] = rd_addr & am[k];
                end else if (m_v[k] && ex_ready) begin
                    m_v[k] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        chk("ex_valid0", 32'(ex_valid0), 32'(m_v[0]));
        chk("id_ready0", 32'(id_ready0), 32'(!m_v[0] || ex_ready));
        chk("ex_a0",     32'(ex_a0),     32'(m_a[0]));
        chk("ex_b0",     32'(ex_b0),     32'(m_b[0]));
        chk("ex_rd0",    32'(ex_rd0),    32'(m_rd[0]));
        chk("ex_valid1", 32'(ex_valid1), 32'(m_v[1]));
        chk("id_ready1", 32'(id_ready1), 32'(!m_v[1] || ex_ready));
        chk("ex_a1",     32'(ex_a1),     32'(m_a[1]));
        chk("ex_b1",     32'(ex_b1),     32'(m_b[1]));
        chk("ex_rd1",    32'(ex_rd1),    32'(m_rd[1]));
    end

    task automatic drv(input bit iv, input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                       input bit we, input logic [2:0] wa, input bit sel,
                       input logic [15:0] win, input logic [15:0] waord, input bit fl, input bit er);
        @(negedge clk);
        id_valid = iv; ra_addr = ra; rb_addr = rb; rd_addr = rd;
        wb_we = we; wb_addr = wa; wb_sel = sel; wb_in = win; wb_aord = waord;
        flush = fl; ex_ready = er;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1);
    endtask

    initial begin
        @(negedge clk); #2;
        chk("rst_ex_valid", 32'(ex_valid0), 32'h0);
        chk("rst_id_ready", 32'(id_ready0), 32'h1);
        chk("rst_ex_a",     32'(ex_a1),     32'h0);
        @(negedge clk); rst = 1'b1;

        // write r2 via ALU result, then read it
        drv(0, 0, 0, 0, 1, 2, 1, 16'h0, 16'h00A5, 0, 1);
        drv(1, 2, 0, 1, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        idle(); #2;
        chk("wr_rd_a0",  32'(ex_a0), 32'hA5);
        chk("wr_rd_a1",  32'(ex_a1), 32'h00A5);
        chk("wr_rd_v",   32'(ex_valid0), 32'h1);
        chk("wr_rd_rd",  32'(ex_rd0), 32'h1);

        // same-cycle bypass to both ports
        drv(1, 1, 1, 2, 1, 1, 0, 16'h003C, 16'h0, 0, 1);
        idle(); #2;
        chk("byp_a0", 32'(ex_a0), 32'h3C);
        chk("byp_b0", 32'(ex_b0), 32'h3C);
        chk("byp_b1", 32'(ex_b1), 32'h003C);

        // stall with a write to the held source register
        drv(1, 3, 3, 3, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drv(1, 3, 3, 3, 1, 3, 0, 16'h0077, 16'h0, 0, 0); #2;
            chk("stall_rdy", 32'(id_ready0), 32'h0);
            chk("stall_a",   32'(ex_a0),     32'h0);
            chk("stall_v",   32'(ex_valid0), 32'h1);
        end
        drv(1, 3, 3, 3, 0, 0, 0, 16'h0, 16'h0, 0, 1);

        // flush against a new input: flush wins, operands hold
        drv(1, 2, 2, 0, 0, 0, 0, 16'h0, 16'h0, 1, 1); #2;
        chk("reissue_a", 32'(ex_a0), 32'h77);
        chk("reissue_v", 32'(ex_valid0), 32'h1);
        drv(1, 2, 2, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1); #2;
        chk("flush_v",   32'(ex_valid0), 32'h0);
        chk("flush_rdy", 32'(id_ready0), 32'h1);
        chk("flush_a",   32'(ex_a0), 32'h77);
        idle(); #2;
        chk("post_flush_v", 32'(ex_valid0), 32'h1);
        chk("post_flush_a", 32'(ex_a0), 32'hA5);

        // hard-zero r0 on the wide instance
        drv(0, 0, 0, 0, 1, 0, 1, 16'h0, 16'hFFFF, 0, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        drv(1, 0, 0, 0, 1, 0, 0, 16'h1234, 16'h0, 0, 1); #2;
        chk("r0_a1", 32'(ex_a1), 32'h0);
        chk("r0_b1", 32'(ex_b1), 32'h0);
        chk("r0_a0", 32'(ex_a0), 32'hFF);
        idle(); #2;
        chk("r0_byp_a1", 32'(ex_a1), 32'h0);
        chk("r0_byp_a0", 32'(ex_a0), 32'h34);
        drv(0, 0, 0, 0, 1, 7, 1, 16'h0, 16'hBEEF, 0, 1);
        drv(1, 7, 7, 7, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        idle(); #2;
        chk("r7_a1",  32'(ex_a1), 32'hBEEF);
        chk("r7_rd1", 32'(ex_rd1), 32'h7);
        chk("r7_a0",  32'(ex_a0), 32'hEF);

        // reset in the middle of a stall
        drv(1, 1, 1, 1, 0, 0, 0, 16'h0, 16'h0, 0, 1);
        drv(1, 2, 2, 2, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_v0", 32'(ex_valid0), 32'h0);
        chk("mid_rst_a0", 32'(ex_a0),     32'h0);
        chk("mid_rst_v1", 32'(ex_valid1), 32'h0);
        chk("mid_rst_rdy", 32'(id_ready0), 32'h1);
        idle(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(1, 3'(i), 3'(i), 3'(i), 0, 0, 0, 16'h0, 16'h0, 0, 1);
            idle(); #2;
            chk("rst_rd_a0", 32'(ex_a0), 32'h0);
            chk("rst_rd_b1", 32'(ex_b1), 32'h0);
        end

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drv(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end
        idle();
        @(negedge clk); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_regfile_stage.md
# id_regfile_stage

Parametrised instruction-decode stage for the RISC pipeline. It holds the general-purpose register file, selects write-back data between the input bus and the ALU/data-memory result, and reads two source operands with same-cycle write-back bypass. Operands are registered into an ID/EX pipeline register with a valid/ready handshake, stall hold and flush. It sits between the IF stage, which supplies decoded register addresses, and the EX stage; write-back arrives from the WB stage.

## Interface
Parameters:
- DW, 8, data width of registers and operand buses
- NREG, 4, number of registers (power of two, ≥2)
- AW, $clog2(NREG), register address width
- ZERO_R0, 0, when 1 register 0 reads as 0 and ignores writes

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  decoded instruction present
- id_ready  out  1  stage can accept the instruction this cycle
- ra_addr  in  AW  source A register
- rb_addr  in  AW  source B register
- rd_addr  in  AW  destination register, passed to EX
- wb_we  in  1  write-back enable
- wb_addr  in  AW  write-back register
- wb_sel  in  1  0 = wb_in, 1 = wb_aord
- wb_in  in  DW  external input data
- wb_aord  in  DW  ALU/data-memory result
- flush  in  1  kill the instruction in ID/EX
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  EX accepts the instruction
- ex_a, ex_b  out  DW  registered operands
- ex_rd  out  AW  registered destination

## Operation
- wb_data = wb_sel ? wb_aord : wb_in.
- Register write: on the rising edge with wb_we=1, reg[wb_addr] <= wb_data; suppressed for address 0 when ZERO_R0=1.
- Operand read is combinational: rd_x = (ZERO_R0 && addr==0) ? 0 : (wb_we && wb_addr==addr) ? wb_data : reg[addr]. Bypass applies to both ports independently, including ra_addr==rb_addr.
- id_ready = !ex_valid || ex_ready.
- ID/EX update, in priority order each edge:
  - flush=1: ex_valid <= 0; ex_a/ex_b/ex_rd hold.
  - id_valid && id_ready: ex_a <= rd_a, ex_b <= rd_b, ex_rd <= rd_addr, ex_valid <= 1.
  - ex_valid && ex_ready (no new input): ex_valid <= 0.
  - otherwise hold (stall).
- Write-back is independent of handshake state; a write during a stall updates the file but not the held ex_a/ex_b.
- No width growth; all data paths are DW bits.

## Timing
- Reset (rst=0, asynchronous): all registers 0, ex_valid=0, ex_a=ex_b=0, ex_rd=0. id_ready=1 immediately.
- Read-to-ex latency: 1 cycle. Write-to-read: 0 cycles via bypass, then from the array.
- Throughput: 1 instruction per cycle while ex_ready=1.
- Flush and an accepted input in the same cycle: the flush wins; the input is dropped and id_ready still reads 1 if ex_valid=0.
- Reset asserted mid-stall discards the held instruction; register contents are lost.

## Structure
- Shared package: a write-back select enum (WB_IN=0, WB_AORD=1). DW/NREG defaults stay as module parameters.
- One sub-module: regfile_bypass (array, write port, two bypassed read ports, ZERO_R0). Mux, handshake and ID/EX register live in the top.

## Test plan
- Reset: drive rst=0 mid-run -> ex_valid=0, ex_a=ex_b=0 at once; after release, reading r0..r3 gives 0.
- Write then read: wb_we=1, wb_addr=2, wb_sel=1, wb_aord=8'hA5; next cycle ra=2 with id_valid=1 -> ex_a=8'hA5 one cycle later.
- Bypass: in the same cycle, wb_we=1 to r1 with wb_in=8'h3C (wb_sel=0), and ra=rb=1, id_valid=1 -> ex_a=ex_b=8'h3C on the next edge.
- Stall: ex_valid=1, ex_ready=0 for 3 cycles, with a write to the source register during the stall -> id_ready=0 and ex_a unchanged throughout; the new value is seen only after re-issue.
- Flush with input: flush=1, id_valid=1 -> ex_valid=0 next cycle; the next instruction is accepted normally.
- ZERO_R0=1, NREG=8, DW=16: write 16'hFFFF to r0, then read r0 -> 0; bypass to r0 is also 0; r7 operates normally.
